param_memory_system: RTL and testbench
======================================

Name: param_memory_system

Overview:
- Parametrised, clocked successor to the 4 x 8-bit store/address memory system: DEPTH words of DATA_W bits.
- Has one synchronous write port, one registered read port and a per-word valid bit.
- Has a multi-cycle clear sweep with a busy indication.
- Sits between lab datapath/controller logic and the board I/O. Storage replaces the per-byte cells and address demux/mux.

Parameters:
- DATA_W, 8, bits per word; 1 or greater.
- DEPTH, 4, number of words; 2 or greater, need not be a power of two.
- ADDR_W, $clog2(DEPTH), localparam address width; not overridable.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe (replaces store).
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- rd_hit  out  1  addressed word was valid at read time.
- rd_ack  out  1  one-cycle pulse: rd_data and rd_hit updated.
- clr_req  in  1  start clear sweep.
- busy  out  1  clear sweep in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset:
  - rd_data=0, rd_hit=0, rd_ack=0, busy=0.
  - All valid bits cleared; FSM to IDLE.
  - Word storage is not reset; it is unreadable until rewritten because it is invalid.
  - Reset has priority over every other input.
  - Reset during CLEAR aborts the sweep; IDLE follows with all valid bits cleared.
- Write:
  - Applies when wr_en=1, busy=0 and wr_addr<DEPTH.
  - On the edge: mem[wr_addr]<=wr_data and valid[wr_addr]<=1.
  - Writes while busy=1 are dropped silently.
  - Writes with wr_addr>=DEPTH are ignored.
- Read:
  - When rd_en=1, rd_ack=1 on the next cycle.
  - If rd_addr<DEPTH and valid: rd_data=mem[rd_addr], rd_hit=1.
  - Otherwise: rd_data=0, rd_hit=0.
  - rd_data and rd_hit hold between reads; rd_ack=0 when rd_en=0.
  - Reads are accepted in IDLE and CLEAR.
- Same-cycle read and write to the same address: the read returns the old word and old valid (read-before-write), unless the macro below is enabled.
- FSM states:
  - IDLE: clr_req=1 -> CLEAR, clr_ptr=0, busy=1 from the next cycle.
  - CLEAR: each cycle valid[clr_ptr]<=0 and clr_ptr++. After clearing DEPTH-1 -> IDLE, busy=0 on the next cycle. busy lasts exactly DEPTH cycles.
  - clr_req in CLEAR is ignored (no restart).
- Clear and write in the same cycle as clr_req while IDLE: the write completes, then the sweep invalidates it.
- A read during CLEAR of an already-swept word returns rd_hit=0; an unswept valid word still hits.
- clr_ptr wraps at DEPTH, not 2^ADDR_W.

Optional Feature:
- Macro: MEMORY_SYSTEM_BYPASS_EN.
- Defined: a same-cycle accepted write and rd_en to the same in-range address forward wr_data, so rd_data=wr_data and rd_hit=1 next cycle. This holds only when the write is accepted (busy=0).
- Undefined: read-before-write as above.
- No port changes either way.

Decomposition:
- Package memory_system_pkg: FSM state enum (ST_IDLE, ST_CLEAR) and a function computing ADDR_W from DEPTH.
- Sub-module mem_word_array: storage array plus valid bits, write port and combinational read. The top level holds the FSM, the output registers and the bypass logic.

Test Plan:
- Reset, then rd_en at each of addr 0..3 -> rd_ack=1 each following cycle, rd_hit=0, rd_data=0.
- Write 0xA5 to addr 2, read addr 2 next cycle -> rd_data=0xA5, rd_hit=1; read addr 1 -> rd_hit=0, rd_data=0.
- Write 0x3C to addr 1 with rd_en addr 1 in the same cycle:
  - Macro undefined -> rd_hit=0, rd_data=0.
  - Macro defined -> rd_data=0x3C, rd_hit=1.
- Fill all 4 words, pulse clr_req:
  - busy=1 for exactly 4 cycles.
  - A write of 0xFF to addr 0 during busy is dropped.
  - Reading addr 3 in the 2nd busy cycle -> hit=1.
  - After busy falls, all reads -> rd_hit=0.
- DEPTH=5, DATA_W=16: write 0xBEEF to addr 4 and read back -> hit.
  - Write to addr 6 -> no effect.
  - Read addr 6 -> rd_hit=0, rd_data=0.
  - Clear sweep -> busy=1 for 5 cycles.
- Assert reset in the 2nd cycle of CLEAR -> next cycle busy=0, FSM IDLE, all reads miss, new clr_req restarts a full sweep.

Source files
------------

// File: rtl/memory_system_pkg.sv
// memory_system_pkg: shared FSM state type and address-width helper for the memory system.
package memory_system_pkg;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/mem_word_array.sv
// mem_word_array: DEPTH-word storage with per-word valid bits, one write port and a combinational read.
module mem_word_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_hit_o
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic              wr_ok, rd_ok;
  assign wr_ok = wr_en_i && ({1'b0, wr_addr_i} < LIMIT);
  assign rd_ok = {1'b0, rd_addr_i} < LIMIT;
  // Data is never reset; the valid bits alone decide what is readable.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_addr_i] <= wr_data_i;
  end
  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else begin
      if (wr_ok) valid_q[wr_addr_i] <= 1'b1;
      if (clr_en_i) valid_q[clr_addr_i] <= 1'b0;
    end
  end
  assign rd_hit_o  = rd_ok && valid_q[rd_addr_i];
  assign rd_data_o = rd_hit_o ? mem_q[rd_addr_i] : '0;
endmodule

// File: rtl/param_memory_system.sv
// param_memory_system: DEPTH x DATA_W store with valid bits, registered read port and clear sweep.
// Define MEMORY_SYSTEM_BYPASS_EN to forward an accepted same-cycle write to a matching read.
module param_memory_system
  import memory_system_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_hit,
  output logic              rd_ack,
  input  logic              clr_req,
  output logic              busy
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              clr_en, wr_acc, byp, arr_hit, rd_hit_d, rd_hit_q, rd_ack_q;
  logic [DATA_W-1:0] arr_data, rd_data_d, rd_data_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end
  always_comb begin
    state_d   = (state_q == ST_IDLE) ? (clr_req ? ST_CLEAR : ST_IDLE)
                                     : ((clr_ptr_q == LAST) ? ST_IDLE : ST_CLEAR);
    clr_ptr_d = (state_q == ST_CLEAR && clr_ptr_q != LAST) ? clr_ptr_q + 1'b1 : '0;
  end
  always_comb begin
    busy   = (state_q == ST_CLEAR);
    clr_en = busy;
    wr_acc = wr_en && !busy;
  end
  mem_word_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .clr_en_i  (clr_en),
    .clr_addr_i(clr_ptr_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (arr_data),
    .rd_hit_o  (arr_hit)
  );
`ifdef MEMORY_SYSTEM_BYPASS_EN
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  assign byp = wr_acc && (wr_addr == rd_addr) && ({1'b0, wr_addr} < LIMIT);
`else
  assign byp = 1'b0;
`endif
  assign rd_data_d = byp ? wr_data : arr_data;
  assign rd_hit_d  = byp | arr_hit;
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ack_q  <= 1'b0;
      rd_hit_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_data_d;
        rd_hit_q  <= rd_hit_d;
      end
    end
  end
  assign rd_data = rd_data_q;
  assign rd_hit  = rd_hit_q;
  assign rd_ack  = rd_ack_q;
endmodule

// File: tb/tb_param_memory_system.sv
// tb_param_memory_system: two DUT configurations (4x8 and 5x16) driven from shared random/directed stimulus, scoreboard-checked.
module tb_param_memory_system;
`ifdef MEMORY_SYSTEM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  typedef struct packed {logic [15:0] data; logic hit;} exp_t;
  logic        clk = 1'b0, reset = 1'b1, wr_en = 1'b0, rd_en = 1'b0, clr_req = 1'b0;
  logic [2:0]  wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic [7:0]  rd_data_a;
  logic [15:0] rd_data_b;
  logic        rd_hit_a, rd_ack_a, busy_a, rd_hit_b, rd_ack_b, busy_b;
  exp_t        q_a[$], q_b[$];
  int          n_checks = 0, n_errors = 0;
  int          depth[2] = '{4, 5};
  logic [15:0] m_mem[2][8];
  bit          m_val[2][8];
  int          m_busy[2];
  bit          m_ack[2];
  bit          started = 1'b0;

  param_memory_system #(.DATA_W(8), .DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr[1:0]), .wr_data(wr_data[7:0]),
    .rd_en(rd_en), .rd_addr(rd_addr[1:0]), .rd_data(rd_data_a), .rd_hit(rd_hit_a),
    .rd_ack(rd_ack_a), .clr_req(clr_req), .busy(busy_a));
  param_memory_system #(.DATA_W(16), .DEPTH(5)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_hit(rd_hit_b),
    .rd_ack(rd_ack_b), .clr_req(clr_req), .busy(busy_b));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a sweep occupies DEPTH cycles and retires word k in its k-th cycle.
  task automatic model_step(input int i);
    int d = depth[i];
    logic [2:0] wa = (i == 0) ? {1'b0, wr_addr[1:0]} : wr_addr;
    logic [2:0] ra = (i == 0) ? {1'b0, rd_addr[1:0]} : rd_addr;
    logic [15:0] wd = (i == 0) ? {8'h0, wr_data[7:0]} : wr_data;
    bit wacc;
    exp_t e;
    if (reset) begin
      for (int k = 0; k < 8; k++) m_val[i][k] = 1'b0;
      m_busy[i] = 0;
      m_ack[i] = 1'b0;
      return;
    end
    wacc = wr_en && m_busy[i] == 0 && int'(wa) < d;
    m_ack[i] = rd_en;
    if (rd_en) begin
      e.hit = int'(ra) < d && m_val[i][ra];
      e.data = e.hit ? m_mem[i][ra] : 16'h0;
      if (BYPASS && wacc && wa == ra) begin
        e.hit = 1'b1;
        e.data = wd;
      end
      if (i == 0) q_a.push_back(e);
      else q_b.push_back(e);
    end
    if (wacc) begin
      m_mem[i][wa] = wd;
      m_val[i][wa] = 1'b1;
    end
    if (m_busy[i] > 0) begin
      m_val[i][d - m_busy[i]] = 1'b0;
      m_busy[i]--;
    end else if (clr_req) m_busy[i] = d;
  endtask

  always @(posedge clk) begin
    if (reset) started <= 1'b1;
    model_step(0);
    model_step(1);
  end

  task automatic mon(input int i, input logic [15:0] data, input logic hit, input logic ack, input logic bsy);
    exp_t e;
    check($sformatf("busy[%0d]", i), {15'h0, bsy}, {15'h0, m_busy[i] != 0});
    check($sformatf("rd_ack[%0d]", i), {15'h0, ack}, {15'h0, m_ack[i]});
    if (ack) begin
      if ((i == 0 ? q_a.size() : q_b.size()) == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ack[%0d]: got ack expected none at %0t", i, $time);
      end else begin
        e = (i == 0) ? q_a.pop_front() : q_b.pop_front();
        check($sformatf("rd_data[%0d]", i), data, e.data);
        check($sformatf("rd_hit[%0d]", i), {15'h0, hit}, {15'h0, e.hit});
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      mon(0, {8'h0, rd_data_a}, rd_hit_a, rd_ack_a, busy_a);
      mon(1, rd_data_b, rd_hit_b, rd_ack_b, busy_b);
    end
  end

  task automatic step(input bit r, input bit we, input int wa, input int wd, input bit re, input int ra, input bit cr);
    @(negedge clk);
    reset = r; wr_en = we; wr_addr = 3'(wa); wr_data = 16'(wd);
    rd_en = re; rd_addr = 3'(ra); clr_req = cr;
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wr(input int a, input int d);
    step(0, 1, a, d, 0, 0, 0);
  endtask
  task automatic rd(input int a);
    step(0, 0, 0, 0, 1, a, 0);
  endtask
  task automatic fill();
    for (int a = 0; a < 5; a++) wr(a, int'($urandom_range(0, 65535)));
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("reset_rd_data_a", {8'h0, rd_data_a}, 16'h0);
    check("reset_rd_hit_a", {15'h0, rd_hit_a}, 16'h0);
    check("reset_rd_ack_a", {15'h0, rd_ack_a}, 16'h0);
    check("reset_busy_a", {15'h0, busy_a}, 16'h0);
    check("reset_rd_data_b", rd_data_b, 16'h0);
    check("reset_busy_b", {15'h0, busy_b}, 16'h0);
    for (int a = 0; a < 4; a++) rd(a);
    wr(2, 'hA5); rd(2); rd(1);
    step(0, 1, 1, 'h3C, 1, 1, 0);
    idle(1);
    fill();
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 'hFF, 0, 0, 0);
    rd(3);
    idle(4);
    for (int a = 0; a < 8; a++) rd(a);
    wr(4, 'hBEEF); rd(4);
    wr(6, 'h1234); rd(6); rd(4);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(6);
    fill();
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 8; a++) rd(a);
    fill();
    step(0, 0, 0, 0, 0, 0, 1);
    idle(6);
    for (int a = 0; a < 5; a++) rd(a);
    repeat (600) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 65535)), $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
           $urandom_range(0, 19) == 0);
    end
    idle(3);
    check("pending_a", 16'(q_a.size()), 16'h0);
    check("pending_b", 16'(q_b.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
